// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller, the external ALU and a future decoder:
// opcode values, controller state encoding and instruction field positions.
package alu_ctrl_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_AW    = 3;
  localparam int FIELD_W   = 3;
  localparam int OP_LSB    = 13;
  localparam int RD_LSB    = 10;
  localparam int RA_LSB    = 7;
  localparam int RB_LSB    = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOT = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } alu_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    alu_opcode_e         op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   ra;
    logic [REG_AW-1:0]   rb;
  } instr_t;

  // Bits [3:0] of the instruction word carry nothing.
  function automatic instr_t decode(input logic [15:0] w);
    instr_t d;
    d.op = alu_opcode_e'(w[OP_LSB +: FIELD_W]);
    d.rd = w[RD_LSB +: FIELD_W];
    d.ra = w[RA_LSB +: FIELD_W];
    d.rb = w[RB_LSB +: FIELD_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_reg_file8.sv
// 8-entry register file: two combinational read ports, one write port committed
// on the rising edge; synchronous reset clears every entry.
module reg_file8
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  output logic [WIDTH-1:0]  rdata_b_o
);

  logic [WIDTH-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU sequencer: IDLE/READ/EXEC/WB, one instruction per 4 cycles,
// done pulses in WB with result/zero/err valid alongside it.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 instr_ready,
  input  logic                 ld_en,
  input  logic [2:0]           ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic [OP_SIZE-1:0]   alu_op,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 zero,
  output logic                 err
);

  state_e               state_q, state_d;
  instr_t               ins_q, ins_d;
  logic [OP_SIZE-1:0]   alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 zero_q, zero_d, err_q, err_d, done_q, done_d;
  logic                 div0;

  logic                 rf_we;
  logic [REG_AW-1:0]    rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  reg_file8 #(.WIDTH(WORD_SIZE)) u_rf (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ins_q.ra),
    .raddr_b_i (ins_q.rb),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  always_comb begin
    state_d  = state_q;
    ins_d    = ins_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    div0     = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    unique case (state_q)
      ST_IDLE: begin
        rf_we = ld_en;
        if (instr_valid) begin
          ins_d   = decode(instr[15:0]);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        alu_op_d = OP_SIZE'(ins_q.op);
        alu_a_d  = rf_rdata_a;
        alu_b_d  = rf_rdata_b;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        // Captured here so result/zero/err are already valid while done is high.
        div0     = (ins_q.op == OP_DIV) && (alu_b_q == '0);
        result_d = div0 ? '1 : alu_out;
        zero_d   = !div0 && (alu_out == '0);
        err_d    = div0;
        done_d   = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        rf_we    = !err_q;
        rf_waddr = ins_q.rd;
        rf_wdata = result_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ins_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ins_q    <= ins_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with a stand-in ALU and an arithmetic reference model of
// the register file and opcode semantics.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        done, zero, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;
  int unsigned model_rf [8];

  alu_ctrl #(.WORD_SIZE(16), .OP_SIZE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .err         (err)
  );

  always #5 clk = ~clk;

  // External combinational ALU that the controller drives.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = ~alu_a;
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a ^ alu_b;
      3'd6: alu_out = alu_a * alu_b;
      3'd7: alu_out = (alu_b == '0) ? '0 : alu_a / alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void ref_alu(input int op, input int unsigned a, input int unsigned b,
                                  output int unsigned r, output bit e);
    e = 1'b0;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a + 65536 - b) % 65536;
      2: r = 65535 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * b) % 65536;
      default: begin
        if (b == 0) begin
          e = 1'b1;
          r = 65535;
        end else begin
          r = a / b;
        end
      end
    endcase
  endfunction

  function automatic int unsigned rand_val();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 65535;
      2: return $urandom_range(0, 15);
      default: return $urandom_range(0, 65535);
    endcase
  endfunction

  task automatic load(input int a, input int unsigned v);
    instr_valid = 1'b0;
    ld_en   = 1'b1;
    ld_addr = a[2:0];
    ld_data = v[15:0];
    model_rf[a] = v;
    step();
    ld_en = 1'b0;
  endtask

  // One full instruction starting in IDLE; returns in the following IDLE cycle.
  task automatic issue(input int op, input int rd, input int ra, input int rb,
                       input bit hold, input bit same_ld, input int la,
                       input int unsigned ldv, input string tag);
    int unsigned a, b, r;
    bit e;
    check({tag, ":ready_idle"}, {31'd0, instr_ready}, 32'd1);
    if (same_ld) begin
      ld_en   = 1'b1;
      ld_addr = la[2:0];
      ld_data = ldv[15:0];
      model_rf[la] = ldv;
    end
    instr_valid = 1'b1;
    instr = {op[2:0], rd[2:0], ra[2:0], rb[2:0], 4'($urandom)};
    a = model_rf[ra];
    b = model_rf[rb];
    ref_alu(op, a, b, r, e);
    step();
    check({tag, ":ready_read"}, {31'd0, instr_ready}, 32'd0);
    check({tag, ":done_read"}, {31'd0, done}, 32'd0);
    instr_valid = hold;
    instr   = 16'($urandom);
    ld_en   = 1'b1;
    ld_addr = 3'($urandom);
    ld_data = 16'($urandom);
    step();
    check({tag, ":alu_op"}, {29'd0, alu_op}, op);
    check({tag, ":alu_a"}, {16'd0, alu_a}, a);
    check({tag, ":alu_b"}, {16'd0, alu_b}, b);
    check({tag, ":done_exec"}, {31'd0, done}, 32'd0);
    ld_addr = 3'($urandom);
    ld_data = 16'($urandom);
    step();
    check({tag, ":done_wb"}, {31'd0, done}, 32'd1);
    check({tag, ":result"}, {16'd0, result}, r);
    check({tag, ":zero"}, {31'd0, zero}, (r == 0 && !e) ? 32'd1 : 32'd0);
    check({tag, ":err"}, {31'd0, err}, {31'd0, e});
    check({tag, ":ready_wb"}, {31'd0, instr_ready}, 32'd0);
    if (!e) model_rf[rd] = r;
    step();
    ld_en = 1'b0;
    if (!hold) instr_valid = 1'b0;
    check({tag, ":done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_rf[i] = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);

    load(1, 5); load(2, 3);
    issue(0, 3, 1, 2, 0, 0, 0, 0, "add");
    issue(4, 0, 3, 3, 0, 0, 0, 0, "rd_r3");
    load(2, 5);
    issue(1, 4, 1, 2, 0, 0, 0, 0, "sub_zero");
    load(1, 100); load(2, 0);
    issue(7, 5, 1, 2, 0, 0, 0, 0, "div0");
    issue(4, 6, 5, 5, 0, 0, 0, 0, "rd_r5");
    load(1, 16'h0100); load(2, 16'h0100);
    issue(6, 3, 1, 2, 0, 0, 0, 0, "mul_wrap");
    load(1, 16'hFFFF); load(2, 1);
    issue(0, 3, 1, 2, 0, 0, 0, 0, "add_wrap");
    issue(2, 7, 2, 1, 0, 0, 0, 0, "not");
    issue(7, 6, 1, 2, 0, 0, 0, 0, "div");
    issue(0, 2, 1, 1, 0, 1, 1, 42, "same_cycle_ld");
    issue(0, 1, 1, 1, 0, 0, 0, 0, "rd_eq_ra");
    issue(4, 0, 1, 1, 0, 0, 0, 0, "rd_r1");

    issue(5, 3, 1, 2, 1, 0, 0, 0, "stream0");
    issue(3, 4, 3, 1, 1, 0, 0, 0, "stream1");
    issue(0, 5, 4, 3, 0, 0, 0, 0, "stream2");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 7), rand_val());
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 7), rand_val(), "rand");
    end
    instr_valid = 1'b0;
    step();

    load(1, 9); load(2, 7);
    issue(0, 3, 1, 2, 0, 0, 0, 0, "pre_rst");
    instr_valid = 1'b1;
    instr = {3'd0, 3'd4, 3'd1, 3'd2, 4'd0};
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_rf[i] = 0;
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);
    check("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    step();
    check("mid_rst_no_done", {31'd0, done}, 32'd0);
    issue(4, 0, 1, 2, 0, 0, 0, 0, "rf_cleared_12");
    issue(4, 0, 3, 4, 0, 0, 0, 0, "rf_cleared_34");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
